// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM state
// encoding, default datapath width and the response flag bundle.
package alu_sched_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned OPC_W         = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'd3;
  localparam logic [OPC_W-1:0] OP_MUL = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by all requesters.
// Ports:
//   opcode  - operation select (ADD/SUB/AND/OR/MUL, others illegal)
//   input1  - operand A
//   input2  - operand B
//   result  - WIDTH-bit truncated result (0 on illegal opcode)
//   carry   - ADD carry-out, SUB borrow, MUL high-half non-zero
//   zero    - result == 0
//   sign    - result MSB
//   err     - illegal opcode
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             err
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH:0] sum;
  logic [PW-1:0]  prod;

  assign sum  = {1'b0, input1} + {1'b0, input2};
  assign prod = PW'(input1) * PW'(input2);

  // Result/carry select; flags derive from the selected result.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = input1 - input2;
        carry  = (input1 < input2);
      end
      OP_AND: result = input1 & input2;
      OP_OR:  result = input1 | input2;
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        carry  = |prod[PW-1:WIDTH];
      end
      default: err = 1'b1;
    endcase
    zero = (result == '0);
    sign = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   reqValid/Ready   - per-requester request handshake (reqReady one-hot,
//                      combinational in the grant cycle)
//   reqOpcode        - packed 4-bit opcodes, slice i for requester i
//   reqInput1/2      - packed WIDTH-bit operands
//   rspValid/Ready   - response handshake
//   rspId            - owner of the response
//   result, *Flag    - registered ALU result and flags
//   busy             - scheduler is executing or holding a response
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = $clog2(NUM_REQ),
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         reqValid,
  output logic [NUM_REQ-1:0]         reqReady,
  input  logic [OPC_W*NUM_REQ-1:0]   reqOpcode,
  input  logic [WIDTH*NUM_REQ-1:0]   reqInput1,
  input  logic [WIDTH*NUM_REQ-1:0]   reqInput2,
  output logic                       rspValid,
  input  logic                       rspReady,
  output logic [ID_W-1:0]            rspId,
  output logic [WIDTH-1:0]           result,
  output logic                       carryFlag,
  output logic                       zeroFlag,
  output logic                       signFlag,
  output logic                       errFlag,
  output logic                       busy
);

  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OPC_W-1:0] op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [ID_W-1:0]  id_q;
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             busy_q;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  int               scan_idx;
  logic [OPC_W-1:0] sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [CNT_W-1:0] cnt_init_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_sign;
  logic             alu_err;

  // Rotating-priority search; scanning backwards lets the requester
  // closest to rr_ptr_q overwrite any farther candidate.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
      if (reqValid[ID_W'(scan_idx)]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(scan_idx);
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = reqOpcode[i*OPC_W +: OPC_W];
        sel_a  = reqInput1[i*WIDTH +: WIDTH];
        sel_b  = reqInput2[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is only offered from IDLE and never while reset is asserted.
  always_comb begin
    reqReady = '0;
    if (rst_n && (state_q == ST_IDLE) && grant_vld) begin
      reqReady[grant_idx] = 1'b1;
    end
  end

  assign rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign cnt_init_d = (sel_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .opcode (op_q),
    .input1 (a_q),
    .input2 (b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero),
    .sign   (alu_sign),
    .err    (alu_err)
  );

  // Scheduler FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            id_q     <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_init_d;
            state_q  <= ST_EXEC;
            busy_q   <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            result_q    <= alu_result;
            flags_q     <= '{carry: alu_carry, zero: alu_zero, sign: alu_sign, err: alu_err};
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rspReady) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rspValid  = rsp_valid_q;
  assign rspId     = rsp_id_q;
  assign result    = result_q;
  assign carryFlag = flags_q.carry;
  assign zeroFlag  = flags_q.zero;
  assign signFlag  = flags_q.sign;
  assign errFlag   = flags_q.err;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler with a behavioural model.
module tb_alu_req_scheduler;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int MULC = 2;

  typedef logic [W+4+IDW-1:0] rsp_t;
  typedef struct packed {
    logic [W-1:0] res;
    logic c;
    logic z;
    logic s;
    logic e;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   reqValid = '0;
  logic [N-1:0]   reqReady;
  logic [4*N-1:0] reqOpcode = '0;
  logic [W*N-1:0] reqInput1 = '0;
  logic [W*N-1:0] reqInput2 = '0;
  logic           rspValid;
  logic           rspReady = 1'b1;
  logic [IDW-1:0] rspId;
  logic [W-1:0]   result;
  logic           carryFlag, zeroFlag, signFlag, errFlag, busy;

  int total = 0;
  int bad = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  alu_req_scheduler #(
    .WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .MUL_CYCLES(MULC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqOpcode(reqOpcode),
    .reqInput1(reqInput1), .reqInput2(reqInput2),
    .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId),
    .result(result), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
    .signFlag(signFlag), .errFlag(errFlag), .busy(busy)
  );

  // Reference arithmetic in plain integers.
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    int ua, ub, r;
    ua = int'(a);
    ub = int'(b);
    r = 0;
    x = '0;
    case (int'(op))
      0: begin r = ua + ub; x.c = (r > 255); end
      1: begin r = ua - ub; x.c = (ua < ub); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: begin r = ua * ub; x.c = (r > 255); end
      default: x.e = 1'b1;
    endcase
    x.res = 8'(r & 255);
    x.z = (x.res == 8'd0);
    x.s = x.res[7];
    return x;
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == 4'd4) ? 1 + MULC : 2;
  endfunction

  // First requesting index when walking upward from ptr.
  function automatic int ref_grant(input logic [N-1:0] mask, input int ptr);
    int g;
    g = -1;
    for (int k = 0; k < N && g < 0; k++) begin
      if (mask[(ptr + k) % N]) g = (ptr + k) % N;
    end
    return g;
  endfunction

  function automatic rsp_t exp_rsp(input int g);
    exp_t e;
    e = ref_alu(reqOpcode[g*4 +: 4], reqInput1[g*W +: W], reqInput2[g*W +: W]);
    return {e.res, e.c, e.z, e.s, e.e, IDW'(g)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    reqOpcode[i*4 +: 4] = op;
    reqInput1[i*W +: W] = a;
    reqInput2[i*W +: W] = b;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(5, 15));
    return 4'($urandom_range(0, 4));
  endfunction

  // Returns at the negedge of the first cycle with a grant.
  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (reqReady !== '0) ok = 1'b1;
      else tick();
    end
  endtask

  // Called one cycle after the grant; cyc counts cycles since the grant.
  task automatic wait_rsp(output int cyc, output rsp_t r);
    cyc = -1;
    r = '0;
    for (int t = 1; t <= 20 && cyc < 0; t++) begin
      @(negedge clk);
      if (rspValid === 1'b1) begin
        cyc = t;
        r = {result, carryFlag, zeroFlag, signFlag, errFlag, rspId};
      end else begin
        tick();
      end
    end
  endtask

  task automatic transact(input logic [N-1:0] mask, output logic [N-1:0] gnt, output int lat, output rsp_t r);
    logic ok;
    reqValid = mask;
    gnt = '0;
    lat = -1;
    r = '0;
    wait_grant(ok);
    if (ok) begin
      gnt = reqReady;
      tick();
      reqValid = '0;
      wait_rsp(lat, r);
      tick();
    end else begin
      reqValid = '0;
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] gnt;
    int lat, g;
    rsp_t r, er;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reqValid = N'($urandom);
      reqOpcode = 16'($urandom);
      @(negedge clk);
      total++;
      if ({reqReady, rspValid, result, busy, rspId, carryFlag, zeroFlag, signFlag, errFlag} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got rr=%b rv=%b res=%h busy=%b id=%0d flags=%b%b%b%b want all 0",
                 reqReady, rspValid, result, busy, rspId, carryFlag, zeroFlag, signFlag, errFlag);
      end
    end
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    for (int i = 0; i < N; i++) set_req(i, 4'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    g = ref_grant('1, model_ptr);
    er = exp_rsp(g);
    transact('1, gnt, lat, r);
    model_ptr = (g + 1) % N;
    total++;
    if (gnt !== (N'(1) << g)) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want %b", gnt, N'(1) << g);
    end
    total++;
    if (r !== er) begin
      bad++;
      $display("FAIL reset_first_rsp: got %h want %h", r, er);
    end
  endtask

  // Single-requester directed vectors: {req, op, a, b}.
  task automatic test_directed(input int n, input logic [27:0] vecs [4]);
    logic [N-1:0] gnt, mask;
    int lat, g, ri;
    rsp_t r, er;
    logic [3:0] op;
    for (int v = 0; v < n; v++) begin
      ri = int'(vecs[v][27:24]);
      op = vecs[v][19:16];
      set_req(ri, op, vecs[v][15:8], vecs[v][7:0]);
      mask = N'(1) << ri;
      g = ref_grant(mask, model_ptr);
      er = exp_rsp(g);
      transact(mask, gnt, lat, r);
      model_ptr = (g + 1) % N;
      total++;
      if (gnt !== mask) begin
        bad++;
        $display("FAIL directed%0d_grant: got %b want %b", v, gnt, mask);
      end
      total++;
      if (lat !== ref_lat(op)) begin
        bad++;
        $display("FAIL directed%0d_latency: got %0d want %0d", v, lat, ref_lat(op));
      end
      total++;
      if (r !== er) begin
        bad++;
        $display("FAIL directed%0d_rsp: got %h want %h", v, r, er);
      end
    end
  endtask

  task automatic test_add();
    logic [27:0] v [4];
    v = '{28'h2_00_F020, 28'h0, 28'h0, 28'h0};
    test_directed(1, v);
  endtask

  task automatic test_sub();
    logic [27:0] v [4];
    v = '{28'h1_01_0505, 28'h3_01_0305, 28'h0, 28'h0};
    test_directed(2, v);
  endtask

  task automatic test_mul_illegal();
    logic [27:0] v [4];
    v = '{28'h0_04_1010, 28'h1_0F_1234, 28'h2_04_0F0F, 28'h0};
    test_directed(3, v);
  endtask

  task automatic test_random();
    logic [N-1:0] gnt, mask;
    int lat, g;
    rsp_t r, er;
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_req(i, rand_op(), W'($urandom), W'($urandom));
      g = ref_grant(mask, model_ptr);
      er = exp_rsp(g);
      transact(mask, gnt, lat, r);
      total++;
      if (gnt !== (N'(1) << g)) begin
        bad++;
        $display("FAIL rand%0d_grant: got %b want %b (mask %b)", it, gnt, N'(1) << g, mask);
      end
      total++;
      if (lat !== ref_lat(reqOpcode[g*4 +: 4])) begin
        bad++;
        $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, ref_lat(reqOpcode[g*4 +: 4]));
      end
      total++;
      if (r !== er) begin
        bad++;
        $display("FAIL rand%0d_rsp: got %h want %h", it, r, er);
      end
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    logic [N-1:0] gnt;
    int lat, g;
    rsp_t r, er;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    for (int i = 0; i < N; i++) set_req(i, 4'(i), W'($urandom), W'($urandom));
    reqValid = '1;
    for (int n = 0; n < N + 1; n++) begin
      g = ref_grant('1, model_ptr);
      er = exp_rsp(g);
      wait_grant(ok);
      gnt = ok ? reqReady : '0;
      total++;
      if (gnt !== (N'(1) << g)) begin
        bad++;
        $display("FAIL rr%0d_grant: got %b want %b", n, gnt, N'(1) << g);
      end
      model_ptr = (g + 1) % N;
      tick();
      set_req(g, 4'(g), W'($urandom), W'($urandom));
      @(negedge clk);
      total++;
      if (reqReady !== '0) begin
        bad++;
        $display("FAIL rr%0d_ready_one_cycle: got %b want 0", n, reqReady);
      end
      tick();
      wait_rsp(lat, r);
      total++;
      if (r !== er || lat < 0) begin
        bad++;
        $display("FAIL rr%0d_rsp: got %h want %h (lat %0d)", n, r, er, lat);
      end
      tick();
    end
    reqValid = '0;
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [N-1:0] mask, gnt;
    int lat, g, g2;
    rsp_t r, er;
    rspReady = 1'b0;
    mask = 4'b1010;
    set_req(1, 4'd0, W'($urandom), W'($urandom));
    set_req(3, 4'd1, W'($urandom), W'($urandom));
    g = ref_grant(mask, model_ptr);
    er = exp_rsp(g);
    reqValid = mask;
    wait_grant(ok);
    gnt = ok ? reqReady : '0;
    total++;
    if (gnt !== (N'(1) << g)) begin
      bad++;
      $display("FAIL bp_grant: got %b want %b", gnt, N'(1) << g);
    end
    model_ptr = (g + 1) % N;
    tick();
    reqValid = mask & ~(N'(1) << g);
    wait_rsp(lat, r);
    total++;
    if (r !== er || lat !== 2) begin
      bad++;
      $display("FAIL bp_rsp: got %h lat %0d want %h lat 2", r, lat, er);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      total++;
      if ({rspValid, result, carryFlag, zeroFlag, signFlag, errFlag, rspId, reqReady} !== {1'b1, er, N'(0)}) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b rsp=%h rr=%b want v=1 rsp=%h rr=0",
                 c, rspValid, {result, carryFlag, zeroFlag, signFlag, errFlag, rspId}, reqReady, er);
      end
    end
    rspReady = 1'b1;
    g2 = ref_grant(reqValid, model_ptr);
    er = exp_rsp(g2);
    tick();
    @(negedge clk);
    total++;
    if ({rspValid, reqReady} !== {1'b0, N'(1) << g2}) begin
      bad++;
      $display("FAIL bp_release: got v=%b rr=%b want v=0 rr=%b", rspValid, reqReady, N'(1) << g2);
    end
    model_ptr = (g2 + 1) % N;
    tick();
    reqValid = '0;
    wait_rsp(lat, r);
    total++;
    if (r !== er) begin
      bad++;
      $display("FAIL bp_second_rsp: got %h want %h", r, er);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic ok;
    int seen, lat;
    rsp_t r;
    // Reset during EXEC of a multi-cycle op.
    set_req(0, 4'd4, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
    reqValid = 4'b0001;
    wait_grant(ok);
    tick();
    reqValid = '0;
    #2;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_exec: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, rspValid, reqReady, result, carryFlag, zeroFlag, signFlag, errFlag} !== '0) begin
      bad++;
      $display("FAIL midrst_exec_async: got busy=%b v=%b rr=%b res=%h want 0", busy, rspValid, reqReady, result);
    end
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rspValid !== 1'b0) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_dropped: got %0d response cycles want 0", seen);
    end
    // Reset while a response is held.
    rspReady = 1'b0;
    set_req(2, 4'd3, W'($urandom), W'($urandom));
    reqValid = 4'b0100;
    wait_grant(ok);
    tick();
    reqValid = '0;
    wait_rsp(lat, r);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({lat > 0, rspValid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_resp_async: got lat=%0d v=%b busy=%b want lat>0 v=0 busy=0", lat, rspValid, busy);
    end
    tick();
    rst_n = 1'b1;
    rspReady = 1'b1;
    model_ptr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_illegal();
    test_random();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational 8-bit ALU between NUM_REQ requesters using round-robin arbitration.
- Latches the granted request's operands, runs the operation (MUL is multi-cycle), and returns registered result and flags on a valid/ready response channel tagged with the requester ID.
- Sits between the instruction-issue logic and the ALU datapath.

Parameters:
- WIDTH, 8, operand/result width.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of rspId.
- MUL_CYCLES, 2, EXEC cycles spent on MUL (>=1); all other ops take 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqValid  in  NUM_REQ  per-requester request valid.
- reqReady  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- reqOpcode  in  4*NUM_REQ  packed opcodes; slice i belongs to requester i.
- reqInput1  in  WIDTH*NUM_REQ  packed operand A.
- reqInput2  in  WIDTH*NUM_REQ  packed operand B.
- rspValid  out  1  response valid.
- rspReady  in  1  response accept.
- rspId  out  ID_W  index of the requester that owns the response.
- result  out  WIDTH  operation result.
- carryFlag  out  1  carry/borrow/overflow flag.
- zeroFlag  out  1  result == 0.
- signFlag  out  1  result[WIDTH-1].
- errFlag  out  1  illegal opcode.
- busy  out  1  state != IDLE.

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, MUL=4; all others are illegal.
- Arithmetic, all results truncated to WIDTH:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: carry = borrow (input1 < input2, unsigned).
  - AND/OR: carry = 0.
  - MUL: result = low WIDTH bits of the 2*WIDTH product; carry = (upper WIDTH bits != 0).
  - Illegal opcode: result = 0, carry = 0, errFlag = 1; otherwise errFlag = 0.
- Reset (async assert, any state): state=IDLE, rrPtr=0, rspValid=0, reqReady=0, rspId=0, result=0, all flags 0, busy=0. Any in-flight op is dropped and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqValid, grant the first asserted requester searching rrPtr, rrPtr+1, … (mod NUM_REQ).
  - reqReady[grant]=1 combinationally in that cycle (cycle T).
  - Opcode, operands and ID are latched at the edge ending T.
  - rrPtr <= grant+1 (mod NUM_REQ). rrPtr changes only on a grant.
  - Go to EXEC; load cycle counter with MUL_CYCLES-1 for MUL, else 0.
- EXEC:
  - reqReady=0.
  - alu_core computes from the latched operands.
  - When the counter is 0, register result and flags, set rspValid=1, go to RESP. Otherwise decrement.
- Latency: rspValid first high in cycle T+2 for non-MUL ops, T+1+MUL_CYCLES for MUL.
- RESP:
  - rspValid, rspId, result and flags stay stable until rspValid && rspReady. On that cycle rspValid <= 0 and state goes to IDLE.
  - No grants in RESP. Earliest next grant is the cycle after the handshake.
  - Throughput is at most 1 op per 3 cycles.
- Requester obligations:
  - Hold reqValid and operands stable until reqReady.
  - Deasserting reqValid before grant is permitted; that requester is simply skipped.
- Simultaneous requests are resolved by the rotating priority only. With all requesters continuously requesting, no requester waits more than NUM_REQ grants.
- busy: 1 in EXEC and RESP.

Decomposition:
- Package alu_sched_pkg:
  - Opcode localparams (ADD..MUL).
  - 2-bit state encoding: IDLE=0, EXEC=1, RESP=2.
  - Default WIDTH.
- Sub-module alu_core (WIDTH param): purely combinational. Inputs opcode, input1, input2. Outputs result, carry, zero, sign, err.
- Arbiter pointer, FSM, counter and response registers live in alu_req_scheduler.

Test Plan:
- Reset: hold rst_n=0 with random reqValid -> reqReady=0, rspValid=0, result=0, busy=0. Release -> first grant goes to requester 0 when all request.
- ADD from req2, 8'hF0+8'h20, grant at T, rspReady=1 -> rspValid at T+2, result=8'h10, carry=1, zero=0, sign=0, rspId=2.
- SUB 8'h05-8'h05 -> result 0, zero=1, carry=0. Then 8'h03-8'h05 -> result 8'hFE, carry=1, sign=1.
- MUL 8'h10*8'h10, MUL_CYCLES=2 -> rspValid at T+3, result=8'h00, carry=1, zero=1. Then opcode 4'hF -> result 0, errFlag=1, zero=1.
- Round-robin: all four reqValid held with distinct ops -> grant order 0,1,2,3,0; rspId matches; each reqReady is exactly one cycle, one-hot.
- Backpressure and mid-op reset:
  - rspReady=0 for 5 cycles -> all response outputs stable, no new reqReady.
  - Assert rst_n=0 during EXEC -> rspValid=0 immediately with no clock edge, and the dropped op never responds.
